// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and FSM state encoding for uart_tx_mmio
// Optional parity build: UART_TX_PARITY_EN widens the state enum and adds PARITY.
package uart_pkg;
    localparam logic [3:0] STATUS_OFS = 4'h0;
    localparam logic [3:0] TXDATA_OFS = 4'h4;
    localparam int ST_READY = 0;
    localparam int ST_IDLE  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_PAR   = 3;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous first-word-fall-through FIFO; pushes when full and pops when empty are ignored
// Ports: clk, rst (sync, active-high), wr_en/din push, rd_en pop, dout head, full, empty, count
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign dout  = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined)
// Ports: clk, rst (sync, active-high); mmio_addr/mmio_we/mmio_wdata stores, mmio_re/mmio_rdata
// registered loads (STATUS at 0x0, TXDATA at 0x4); FPGA_SERIAL_TX serial line, idles high.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mmio_addr,
    input  logic        mmio_we,
    input  logic [7:0]  mmio_wdata,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    output logic        FPGA_SERIAL_TX
);
    localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
    localparam int BW = BIT_PERIOD > 1 ? $clog2(BIT_PERIOD) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
    logic par_bit;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    state_t state, state_n;
    logic push, pop, full, empty, tick, overflow, rd_status, tx_ready, tx_idle;
    logic [7:0] head, shift;
    logic [CW-1:0] count;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx;
    logic [31:0] status;
    assign push      = mmio_we && mmio_addr == TXDATA_OFS;
    assign rd_status = mmio_re && mmio_addr == STATUS_OFS;
    assign pop       = state == IDLE && !empty;
    assign tick      = baud == BW'(BIT_PERIOD - 1);
    assign tx_ready  = count != CW'(FIFO_DEPTH);
    assign tx_idle   = empty && state == IDLE;
    tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   (mmio_wdata),
        .rd_en (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_comb begin
        status           = '0;
        status[ST_READY] = tx_ready;
        status[ST_IDLE]  = tx_idle;
        status[ST_OVF]   = overflow;
        status[ST_PAR]   = PAR_EN;
    end
    // A drop is judged on the pre-edge FIFO state; set beats a coincident STATUS clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_rdata <= '0;
            overflow   <= 1'b0;
        end else begin
            if (mmio_re) mmio_rdata <= mmio_addr == STATUS_OFS ? status : '0;
            overflow <= (push && full) || (overflow && !rd_status);
        end
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = empty ? IDLE : START;
            START:  state_n = tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   state_n = tick && bit_idx == 3'd7 ? PARITY : DATA;
            PARITY: state_n = tick ? STOP : PARITY;
`else
            DATA:   state_n = tick && bit_idx == 3'd7 ? STOP : DATA;
`endif
            STOP:   state_n = tick ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
`ifdef UART_TX_PARITY_EN
        FPGA_SERIAL_TX = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
`else
        FPGA_SERIAL_TX = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
    end
    // Parity is captured at pop because the shift register is consumed during DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (pop) begin
            baud    <= '0;
            bit_idx <= '0;
            shift   <= head;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^head;
`endif
        end else if (state != IDLE) begin
            baud <= tick ? '0 : baud + 1'b1;
            if (tick && state == DATA) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed scoreboard bench for uart_tx_mmio (BIT_PERIOD=10, FIFO_DEPTH=4)
module tb_uart_tx_mmio;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PB = 32'h8;
`else
    localparam int NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif
    localparam int FL = 10 * NB;
    logic clk = 0, rst = 1, mmio_we = 0, mmio_re = 0, line;
    logic [3:0] mmio_addr = 0;
    logic [7:0] mmio_wdata = 0;
    logic [31:0] mmio_rdata, v;
    int n_checks = 0, n_fail = 0, cyc = 0, frames = 0, t = 0, s0;
    bit busy = 0;
    logic [8:0] rx, exp_q[$];
    int starts[$];

    uart_tx_mmio #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_we(mmio_we),
        .mmio_wdata(mmio_wdata), .mmio_re(mmio_re), .mmio_rdata(mmio_rdata),
        .FPGA_SERIAL_TX(line)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {^d, d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic write(input logic [3:0] a, input logic [7:0] d, input bit acc);
        mmio_addr = a; mmio_wdata = d; mmio_we = 1;
        if (acc) exp_q.push_back(exp_of(d));
        @(negedge clk);
        mmio_we = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] r);
        mmio_addr = a; mmio_re = 1;
        @(negedge clk);
        mmio_re = 0;
        r = mmio_rdata;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int i = 0;
        while (frames < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("frame_count_wait", frames, n);
    endtask

    // Line monitor: decodes frames by mid-bit sampling and pops the scoreboard on each stop bit.
    always @(negedge clk) begin
        cyc++;
        if (rst) busy = 0;
        else if (!busy) begin
            if (!line) begin
                busy = 1; t = 0; rx = '0;
                starts.push_back(cyc);
            end
        end else begin
            t++;
            if (t >= 15 && t <= 85 && (t - 15) % 10 == 0) rx[(t - 15) / 10] = line;
`ifdef UART_TX_PARITY_EN
            if (t == 95) rx[8] = line;
`endif
            if (t == FL - 5) begin
                check("stop_bit", line, 1);
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_data", rx, exp_q.pop_front());
                frames++;
                busy = 0;
            end
        end
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            check("line_in_reset", line, 1);
            check("rdata_reset", mmio_rdata, 0);
        end
        rst = 0;
        rd(4'h0, v); check("status_reset", v, 32'h3 | PB);
        write(4'h8, 8'h77, 0);
        rd(4'h8, v); check("read_other_ofs", v, 0);
        rd(4'h4, v); check("read_txdata_ofs", v, 0);
        repeat (30) @(negedge clk);
        check("line_idle_unmapped_write", line, 1);
        check("no_frame_unmapped", frames, 0);

        write(4'h4, 8'hA5, 1);
        check("line_before_pop", line, 1);
        @(negedge clk);
        check("line_start_low", line, 0);
        repeat (FL - 1) @(negedge clk);
        rd(4'h0, v); check("status_last_stop_cycle", v, 32'h1 | PB);
        rd(4'h0, v); check("status_idle_after_frame", v, 32'h3 | PB);
        repeat (3) @(negedge clk);
        check("rdata_hold", mmio_rdata, 32'h3 | PB);
        check("frames_after_a5", frames, 1);

        s0 = starts.size();
        write(4'h4, 8'h00, 1);
        write(4'h4, 8'hFF, 1);
        write(4'h4, 8'h55, 1);
        wait_frames(4, 4 * (FL + 1));
        if (starts.size() >= s0 + 3) begin
            check("gap_1", starts[s0 + 1] - starts[s0], FL + 1);
            check("gap_2", starts[s0 + 2] - starts[s0 + 1], FL + 1);
        end else check("starts_seen", starts.size(), s0 + 3);
        repeat (20) @(negedge clk);

        write(4'h4, 8'h11, 1);
        write(4'h4, 8'h22, 1);
        write(4'h4, 8'h33, 1);
        write(4'h4, 8'h44, 1);
        write(4'h4, 8'h5E, 1);
        write(4'h4, 8'h66, 0);
        rd(4'h0, v); check("status_overflow_set", v, 32'h4 | PB);
        rd(4'h0, v); check("status_overflow_cleared", v, 32'h0 | PB);
        wait_frames(9, 6 * (FL + 1));
        repeat (2 * FL) @(negedge clk);
        check("frames_after_overflow", frames, 9);
        rd(4'h0, v); check("status_after_burst", v, 32'h3 | PB);

`ifdef UART_TX_PARITY_EN
        write(4'h4, 8'h07, 1);
        write(4'h4, 8'h03, 1);
        wait_frames(11, 3 * (FL + 1));
        check("parity_spacing", starts[starts.size() - 1] - starts[starts.size() - 2], FL + 1);
        repeat (20) @(negedge clk);
`endif

        s0 = frames;
        write(4'h4, 8'h3C, 1);
        write(4'h4, 8'h81, 1);
        for (int i = 0; i < 50 && line; i++) @(negedge clk);
        check("reset_test_start", line, 0);
        repeat (44) @(negedge clk);
        rst = 1;
        exp_q.delete();
        @(negedge clk);
        check("line_after_reset", line, 1);
        @(negedge clk);
        rst = 0;
        rd(4'h0, v); check("status_after_reset", v, 32'h3 | PB);
        begin
            int lows = 0;
            repeat (3 * FL) begin
                @(negedge clk);
                if (!line) lows++;
            end
            check("line_low_after_reset", lows, 0);
        end
        check("no_frames_after_reset", frames, s0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
